// File: rtl/fsm_counter_core.sv
// ============================================================================
// Module      : fsm_counter_core
// Description : Run/done responder. It accepts a loop count N, spends N cycles
//               in RUN and then pulses done for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_counter_core #(
  parameter int CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_run,
  input  logic [CNT_WIDTH-1:0] i_num_cnt,
  output logic                 o_idle,
  output logic                 o_running,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_cnt_val
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_zero = '0;
  localparam logic [CNT_WIDTH-1:0] c_one  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_num_cnt;
  logic [CNT_WIDTH-1:0] r_cnt_val;
  logic                 r_idle;
  logic                 r_running;
  logic                 r_done;
  logic [CNT_WIDTH-1:0] w_last_cnt;
  logic                 w_is_done;

  // Final count of a run; only meaningful in RUN, where N is never zero.
  assign w_last_cnt = r_num_cnt - c_one;
  assign w_is_done  = (r_cnt_val == w_last_cnt);

  // Status flags are registered alongside the state so they stay one-hot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_num_cnt <= c_zero;
      r_cnt_val <= c_zero;
      r_idle    <= 1'b1;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_num_cnt <= i_num_cnt;
            r_cnt_val <= c_zero;
            r_idle    <= 1'b0;
            if (i_num_cnt != c_zero) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_is_done) begin
            r_state   <= S_DONE;
            r_cnt_val <= c_zero;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_cnt_val <= r_cnt_val + c_one;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_idle  <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt_val <= c_zero;
          r_idle    <= 1'b1;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign o_idle    = r_idle;
  assign o_running = r_running;
  assign o_done    = r_done;
  assign o_cnt_val = r_cnt_val;

endmodule

`default_nettype wire

// File: tb/tb_fsm_counter_core.sv
// ============================================================================
// Module      : tb_fsm_counter_core
// Description : Self-checking bench for fsm_counter_core against a
//               cycle-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_counter_core;

  localparam int CNT_WIDTH = 7;
  localparam int MAX_N     = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 i_run;
  logic [CNT_WIDTH-1:0] i_num_cnt;
  logic                 o_idle;
  logic                 o_running;
  logic                 o_done;
  logic [CNT_WIDTH-1:0] o_cnt_val;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cycle = 0;

  // Upcoming cycles of the current job: value >= 0 is a RUN cycle showing
  // that count, -1 is the DONE cycle. An empty queue means IDLE.
  int exp_q[$];

  fsm_counter_core #(.CNT_WIDTH(CNT_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_run     (i_run),
    .i_num_cnt (i_num_cnt),
    .o_idle    (o_idle),
    .o_running (o_running),
    .o_done    (o_done),
    .o_cnt_val (o_cnt_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, n_cycle, obs, exp);
    end
  endtask

  // Drive inputs, clock once, advance the model, then check outputs.
  task automatic step(input logic rst, input logic run, input int num);
    int e_idle, e_run, e_done, e_cnt;
    reset     = rst;
    i_run     = run;
    i_num_cnt = num[CNT_WIDTH-1:0];
    @(posedge clk);
    n_cycle++;
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (run) begin
      for (int i = 0; i < num; i++) exp_q.push_back(i);
      exp_q.push_back(-1);
    end
    e_idle = (exp_q.size() == 0) ? 1 : 0;
    e_run  = (exp_q.size() != 0 && exp_q[0] >= 0) ? 1 : 0;
    e_done = (exp_q.size() != 0 && exp_q[0] < 0) ? 1 : 0;
    e_cnt  = e_run ? exp_q[0] : 0;
    #1;
    check("o_idle",    int'(o_idle),    e_idle);
    check("o_running", int'(o_running), e_run);
    check("o_done",    int'(o_done),    e_done);
    check("o_cnt_val", int'(o_cnt_val), e_cnt);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  initial begin
    reset     = 1'b1;
    i_run     = 1'b1;
    i_num_cnt = '0;

    // Reset held with a pending request: must stay idle.
    step(1'b1, 1'b1, 5);
    step(1'b1, 1'b1, 5);

    // Basic run, N=5.
    step(1'b0, 1'b1, 5);
    idle_cycles(8);

    // Zero count goes straight to DONE.
    step(1'b0, 1'b1, 0);
    idle_cycles(3);

    // Maximum count, no wrap.
    step(1'b0, 1'b1, MAX_N);
    idle_cycles(MAX_N + 3);

    // Requests during RUN and DONE are ignored.
    step(1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 9);
    step(1'b0, 1'b0, 9);
    step(1'b0, 1'b1, 9);
    step(1'b0, 1'b1, 9);
    idle_cycles(4);

    // Held request, N=2: period of four cycles.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 2);
    idle_cycles(4);

    // Reset during the fourth RUN cycle, then a clean N=2 job.
    step(1'b0, 1'b1, 10);
    idle_cycles(3);
    step(1'b1, 1'b1, 10);
    step(1'b0, 1'b1, 2);
    idle_cycles(5);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic rst, run;
      int   num;
      rst = ($urandom_range(0, 99) < 2);
      run = ($urandom_range(0, 99) < 35);
      num = ($urandom_range(0, 9) == 0) ? $urandom_range(0, MAX_N)
                                        : $urandom_range(0, 6);
      step(rst, run, num);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
